usr_serial_tx: RTL and testbench

Parallel-to-serial word transmitter that drives the serial input and mode lines of a downstream universal shift register (USR).
- Accepts one WIDTH-bit word per valid/ready handshake.
- Emits the word one bit per clock together with the matching USR shift mode.
- After WIDTH shift cycles, the downstream USR holds the exact word.
- Sits between a word producer and the USR; it is the sending end of the USR's serial-load path.

---
 rtl/usr_serial_tx_pkg.sv | 16 +
 rtl/usr_serial_tx_if.sv | 26 ++
 rtl/usr_serial_tx.sv | 132 +++++++++++++
 tb/tb_usr_serial_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_serial_tx_pkg.sv
// Shared definitions for the USR serial-load path.
// Mode encodings match the downstream universal shift register.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

endpackage

// File: rtl/usr_serial_tx_if.sv
// Word handshake plus serial/mode lines toward the USR.
// master = word producer side, slave = transmitter side.
interface usr_serial_tx_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             ser_bit;
  logic [1:0]       ser_mode;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, in_dir,
    input  in_ready, ser_bit, ser_mode, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_dir,
    output in_ready, ser_bit, ser_mode, busy, done
  );

endinterface

// File: rtl/usr_serial_tx.sv
// Parallel-to-serial word transmitter feeding a USR serial input.
// One word per handshake, one bit per clock, registered outputs.
module usr_serial_tx
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic            clk,
  input  logic            rst,
  usr_serial_tx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             dir, dir_n;
  logic [3:0]       gcnt, gcnt_n;
  logic             ready, ready_n;
  logic             sbit, sbit_n;
  logic [1:0]       mode, mode_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sreg   <= '0;
      dir    <= 1'b0;
      gcnt   <= '0;
      ready  <= 1'b1;
      sbit   <= 1'b0;
      mode   <= MODE_HOLD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sreg   <= sreg_n;
      dir    <= dir_n;
      gcnt   <= gcnt_n;
      ready  <= ready_n;
      sbit   <= sbit_n;
      mode   <= mode_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  // Outputs are computed for the next state so they come out registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    dir_n   = dir;
    gcnt_n  = gcnt;
    ready_n = ready;
    sbit_n  = 1'b0;
    mode_n  = MODE_HOLD;
    busy_n  = busy_q;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (bus.in_valid && ready) begin
          state_n = ST_SHIFT;
          sreg_n  = bus.in_data;
          dir_n   = bus.in_dir;
          cnt_n   = '0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
          sbit_n  = bus.in_dir ? bus.in_data[WIDTH-1]
                               : bus.in_data[0];
          mode_n  = bus.in_dir ? MODE_LEFT : MODE_RIGHT;
        end
      end
      ST_SHIFT: begin
        if (cnt == LAST) begin
          done_n = 1'b1;
          if (GAP > 0) begin
            state_n = ST_GAP;
            gcnt_n  = '0;
            ready_n = 1'b0;
            busy_n  = 1'b1;
          end else begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n  = cnt + CW'(1);
          mode_n = dir ? MODE_LEFT : MODE_RIGHT;
          if (dir) begin
            sreg_n = {sreg[WIDTH-2:0], 1'b0};
            sbit_n = sreg[WIDTH-2];
          end else begin
            sreg_n = {1'b0, sreg[WIDTH-1:1]};
            sbit_n = sreg[1];
          end
        end
      end
      ST_GAP: begin
        // The done cycle counts as gap slot 0.
        if (gcnt == GAP_LAST) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end else begin
          gcnt_n = gcnt + 4'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = ready;
  assign bus.ser_bit  = sbit;
  assign bus.ser_mode = mode;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_usr_serial_tx.sv
// Bench for usr_serial_tx with a behavioural 4-bit USR downstream.
// Covers GAP=0 and GAP=2 instances.
module tb_usr_serial_tx;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic usr_clr;
  logic [3:0] usr0, usr2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  usr_serial_tx_if #(.WIDTH(4)) b0();
  usr_serial_tx_if #(.WIDTH(4)) b2();

  usr_serial_tx #(.WIDTH(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  usr_serial_tx #(.WIDTH(4), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  // Downstream USR models: right shift enters at MSB, left at LSB.
  always @(posedge clk) begin
    if (usr_clr) begin
      usr0 <= 4'b0;
      usr2 <= 4'b0;
    end else begin
      case (b0.ser_mode)
        MODE_RIGHT: usr0 <= {b0.ser_bit, usr0[3:1]};
        MODE_LEFT:  usr0 <= {usr0[2:0], b0.ser_bit};
        default:    usr0 <= usr0;
      endcase
      case (b2.ser_mode)
        MODE_RIGHT: usr2 <= {b2.ser_bit, usr2[3:1]};
        MODE_LEFT:  usr2 <= {usr2[2:0], b2.ser_bit};
        default:    usr2 <= usr2;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (b0.ser_mode === MODE_LOAD || b2.ser_mode === MODE_LOAD) begin
        bad++;
        $display("FAIL mode_11 seen: m0=%b m2=%b", b0.ser_mode, b2.ser_mode);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] data;
    logic       dir;
    logic [3:0] bits;
    logic [1:0] mode;
  } vec_t;

  task automatic send0(input logic [3:0] d, input logic dr,
                       input logic [3:0] eb, input logic [1:0] em,
                       input string tag);
    int w;
    w = 0;
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.in_data  = d;
    b0.in_dir   = dr;
    while (b0.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready"}, b0.in_ready, 1);
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.in_data  = ~d;
    b0.in_dir   = ~dr;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s bit%0d", tag, k), b0.ser_bit, eb[k]);
      chk($sformatf("%s mode%0d", tag, k), b0.ser_mode, em);
      chk($sformatf("%s busy%0d", tag, k), b0.busy, 1);
      chk($sformatf("%s ndone%0d", tag, k), b0.done, 0);
      @(negedge clk);
    end
    chk({tag, " done"}, b0.done, 1);
    chk({tag, " done_mode"}, b0.ser_mode, MODE_HOLD);
    chk({tag, " done_ready"}, b0.in_ready, 1);
    chk({tag, " usr"}, usr0, d);
    @(negedge clk);
    chk({tag, " done_clr"}, b0.done, 0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{data: 4'b0011, dir: 1'b0, bits: 4'b0011, mode: MODE_RIGHT};
    vecs[1] = '{data: 4'b0111, dir: 1'b1, bits: 4'b1110, mode: MODE_LEFT};
    vecs[2] = '{data: 4'b1000, dir: 1'b0, bits: 4'b1000, mode: MODE_RIGHT};
    vecs[3] = '{data: 4'b1000, dir: 1'b1, bits: 4'b0001, mode: MODE_LEFT};
    vecs[4] = '{data: 4'b1101, dir: 1'b1, bits: 4'b1011, mode: MODE_LEFT};

    rst = 1'b1;
    usr_clr = 1'b1;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_dir = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.in_dir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    usr_clr = 1'b0;
    chk("rst ready", b0.in_ready, 1);
    chk("rst mode", b0.ser_mode, MODE_HOLD);
    chk("rst bit", b0.ser_bit, 0);
    chk("rst busy", b0.busy, 0);
    chk("rst done", b0.done, 0);
    chk("rst usr", usr0, 0);

    for (int i = 0; i < 5; i++)
      send0(vecs[i].data, vecs[i].dir, vecs[i].bits, vecs[i].mode,
            $sformatf("vec%0d", i));

    // Back-to-back: second word accepted on the first done cycle.
    @(negedge clk);
    b0.in_valid = 1'b1; b0.in_data = 4'b1010; b0.in_dir = 1'b0;
    @(negedge clk);
    b0.in_data = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b1 bit%0d", k), b0.ser_bit, k % 2);
      chk($sformatf("b2b1 mode%0d", k), b0.ser_mode, MODE_RIGHT);
      @(negedge clk);
    end
    chk("b2b1 done", b0.done, 1);
    chk("b2b1 ready", b0.in_ready, 1);
    chk("b2b1 usr", usr0, 4'b1010);
    @(negedge clk);
    b0.in_valid = 1'b0; b0.in_data = 4'b1111; b0.in_dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b2 bit%0d", k), b0.ser_bit, (k + 1) % 2);
      chk($sformatf("b2b2 mode%0d", k), b0.ser_mode, MODE_RIGHT);
      chk($sformatf("b2b2 ndone%0d", k), b0.done, 0);
      @(negedge clk);
    end
    chk("b2b2 done", b0.done, 1);
    chk("b2b2 usr", usr0, 4'b0101);
    @(negedge clk);
    chk("b2b2 idle", b0.busy, 0);

    // Reset during bit index 2.
    b0.in_valid = 1'b1; b0.in_data = 4'b1100; b0.in_dir = 1'b0;
    @(negedge clk);
    b0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid bit2", b0.ser_bit, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid ready", b0.in_ready, 1);
    chk("mid busy", b0.busy, 0);
    chk("mid mode", b0.ser_mode, MODE_HOLD);
    chk("mid bit", b0.ser_bit, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid nodone%0d", k), b0.done, 0);
      @(negedge clk);
    end
    send0(4'b1001, 1'b0, 4'b1001, MODE_RIGHT, "after_rst");

    // GAP=2 instance.
    @(negedge clk);
    b2.in_valid = 1'b1; b2.in_data = 4'b0110; b2.in_dir = 1'b0;
    chk("gap ready0", b2.in_ready, 1);
    @(negedge clk);
    b2.in_valid = 1'b0; b2.in_data = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("gap bit%0d", k), b2.ser_bit, (k == 1 || k == 2) ? 1 : 0);
      chk($sformatf("gap mode%0d", k), b2.ser_mode, MODE_RIGHT);
      @(negedge clk);
    end
    chk("gap done", b2.done, 1);
    chk("gap done_ready", b2.in_ready, 0);
    chk("gap done_busy", b2.busy, 1);
    chk("gap usr", usr2, 4'b0110);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("gap ready_lo%0d", k), b2.in_ready, 0);
      chk($sformatf("gap busy%0d", k), b2.busy, 1);
      chk($sformatf("gap mode_hold%0d", k), b2.ser_mode, MODE_HOLD);
      chk($sformatf("gap ndone%0d", k), b2.done, 0);
    end
    @(negedge clk);
    chk("gap ready_back", b2.in_ready, 1);
    chk("gap busy_off", b2.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
